cbus_arbiter: RTL and testbench

Shares the single cache bus (CBus) between N cache-side requesters, e.g. ICache at port 0 and DCache at port 1, ahead of the memory/AXI bridge. Selects one requester when idle and locks the grant for the whole burst, uncached single beats included. Releases the grant on the final handshake (`ready && last`). Forwards the granted requester's `cbus_req_t` downstream and routes `cbus_resp_t` back only to that requester.

---
 rtl/cbus_arbiter_pkg.sv | 33 +++
 rtl/cbus_arbiter_picker.sv | 29 ++
 rtl/cbus_arbiter.sv | 92 +++++++++
 tb/tb_cbus_arbiter.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cbus_arbiter_pkg.sv
// Shared CBus types: request/response structs and the arbiter state enum.
package common;

   typedef enum logic [3:0] {
      MLEN1  = 4'd0,
      MLEN2  = 4'd1,
      MLEN4  = 4'd3,
      MLEN8  = 4'd7,
      MLEN16 = 4'd15
   } cbus_len_t;

   typedef struct packed {
      logic        valid;
      logic        is_write;
      logic [2:0]  size;
      logic [63:0] addr;
      logic [7:0]  strobe;
      logic [63:0] data;
      cbus_len_t   len;
   } cbus_req_t;

   typedef struct packed {
      logic        ready;
      logic        last;
      logic [63:0] data;
   } cbus_resp_t;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } cbus_arb_state_t;

endpackage

// File: rtl/cbus_arbiter_picker.sv
// Combinational winner search: first valid port at or after start, wrapping.
module arb_picker #(
   parameter int NUM_REQS = 2,
   parameter int IDX_BITS = $clog2(NUM_REQS)
) (
   input  logic [NUM_REQS-1:0] valids,
   input  logic [IDX_BITS-1:0] start,
   output logic [IDX_BITS-1:0] winner,
   output logic                any_valid
);

   int                  j;
   logic [IDX_BITS-1:0] cand;

   // Scan from the farthest offset down so the nearest valid port wins last.
   always_comb begin
      winner = '0;
      j      = 0;
      cand   = '0;
      for (int k = NUM_REQS - 1; k >= 0; k--) begin
         j    = (int'(start) + k) % NUM_REQS;
         cand = IDX_BITS'(j);
         if (valids[cand]) winner = cand;
      end
   end

   assign any_valid = |valids;

endmodule

// File: rtl/cbus_arbiter.sv
// CBus arbiter: locks one requester for a whole burst, releases on ready && last.
// Define CBUS_ARBITER_ROUND_ROBIN_EN for round robin; otherwise fixed priority (port 0 highest).
//
// state | meaning
// IDLE  | no grant held, outputs zero, picks a winner from valid requests
// BUSY  | grant held by port index until the final handshake
module cbus_arbiter
   import common::*;
#(
   parameter int NUM_REQS = 2,
   parameter int IDX_BITS = $clog2(NUM_REQS)
) (
   input  logic                        clk,
   input  logic                        reset,
   input  cbus_req_t  [NUM_REQS-1:0]   ireqs,
   output cbus_resp_t [NUM_REQS-1:0]   iresps,
   output cbus_req_t                   oreq,
   input  cbus_resp_t                  oresp
);

   cbus_arb_state_t     state;
   logic [IDX_BITS-1:0] index;
   logic [IDX_BITS-1:0] start;
   logic [IDX_BITS-1:0] winner;
   logic                any_valid;
   logic [NUM_REQS-1:0] valids;
   logic                release_hs;

   always_comb begin
      valids = '0;
      for (int i = 0; i < NUM_REQS; i++) valids[i] = ireqs[i].valid;
   end

   assign release_hs = (state == BUSY) && oresp.ready && oresp.last;

`ifdef CBUS_ARBITER_ROUND_ROBIN_EN
   logic [IDX_BITS-1:0] rr;

   always_ff @(posedge clk) begin
      if (!reset) begin
         rr <= '0;
      end else if (release_hs) begin
         rr <= (int'(index) == NUM_REQS - 1) ? '0 : index + IDX_BITS'(1);
      end
   end

   assign start = rr;
`else
   assign start = '0;
`endif

   arb_picker #(
      .NUM_REQS (NUM_REQS),
      .IDX_BITS (IDX_BITS)
   ) u_picker (
      .valids    (valids),
      .start     (start),
      .winner    (winner),
      .any_valid (any_valid)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= IDLE;
         index <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (any_valid) begin
                  index <= winner;
                  state <= BUSY;
               end
            end
            BUSY: begin
               if (release_hs) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Both directions are pure muxes off the registered grant; nothing is buffered.
   always_comb begin
      oreq   = '0;
      iresps = '0;
      if (state == BUSY) begin
         oreq          = ireqs[index];
         iresps[index] = oresp;
      end
   end

endmodule

// File: tb/tb_cbus_arbiter.sv
// Self-checking bench for cbus_arbiter: vector table, directed corner sequences, random vs model.
module tb_cbus_arbiter;
   import common::*;

   localparam int N = 2;
`ifdef CBUS_ARBITER_ROUND_ROBIN_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic                 clk = 1'b0;
   logic                 reset;
   cbus_req_t  [N-1:0]   ireqs;
   cbus_resp_t [N-1:0]   iresps;
   cbus_req_t            oreq;
   cbus_resp_t           oresp;

   int checks = 0;
   int errors = 0;
   int owner  = -1;
   int ptr    = 0;

   always #5 clk = ~clk;

   cbus_arbiter #(.NUM_REQS(N)) dut (
      .clk    (clk),
      .reset  (reset),
      .ireqs  (ireqs),
      .iresps (iresps),
      .oreq   (oreq),
      .oresp  (oresp)
   );

   typedef struct {
      logic [1:0] v;
      logic       rdy;
      logic       lst;
      int         exp_owner;
   } vec_t;

   vec_t tbl[13];

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic int model_pick();
      int base;
      base = RR ? ptr : 0;
      for (int k = 0; k < N; k++)
         if (ireqs[(base + k) % N].valid) return (base + k) % N;
      return -1;
   endfunction

   task automatic compare_model();
      cbus_req_t  e;
      cbus_resp_t er;
      e = '0;
      if (owner >= 0) e = ireqs[owner];
      check("model_oreq", 256'(oreq), 256'(e));
      for (int i = 0; i < N; i++) begin
         er = '0;
         if (i == owner) er = oresp;
         check("model_iresp", 256'(iresps[i]), 256'(er));
      end
   endtask

   task automatic model_update();
      if (!reset) begin
         owner = -1;
         ptr   = 0;
      end else if (owner < 0) begin
         owner = model_pick();
      end else if (oresp.ready && oresp.last) begin
         if (RR) ptr = (owner + 1) % N;
         owner = -1;
      end
   endtask

   task automatic step();
      #1;
      compare_model();
      @(posedge clk);
      model_update();
      @(negedge clk);
   endtask

   task automatic clear_inputs();
      for (int i = 0; i < N; i++) begin
         ireqs[i]      = '0;
         ireqs[i].addr = 64'h1000 * (i + 1);
         ireqs[i].data = 64'hDA7A_0000 + 64'(i);
      end
      oresp = '0;
   endtask

   task automatic do_reset();
      clear_inputs();
      reset = 1'b0;
      step();
      reset = 1'b1;
   endtask

   int beats;
   int grants[$];
   int first_grant;

   initial begin
      tbl[0]  = '{2'b11, 1'b0, 1'b0, -1};
      tbl[1]  = '{2'b11, 1'b1, 1'b0,  0};
      tbl[2]  = '{2'b11, 1'b1, 1'b1,  0};
      tbl[3]  = '{2'b10, 1'b0, 1'b0, -1};
      tbl[4]  = '{2'b10, 1'b1, 1'b1,  1};
      tbl[5]  = '{2'b01, 1'b0, 1'b0, -1};
      tbl[6]  = '{2'b01, 1'b1, 1'b0,  0};
      tbl[7]  = '{2'b11, 1'b1, 1'b0,  0};
      tbl[8]  = '{2'b11, 1'b1, 1'b1,  0};
      tbl[9]  = '{2'b10, 1'b0, 1'b0, -1};
      tbl[10] = '{2'b10, 1'b1, 1'b1,  1};
      tbl[11] = '{2'b00, 1'b0, 1'b0, -1};
      tbl[12] = '{2'b00, 1'b1, 1'b1, -1};

      // Initial reset: DUT state is unknown before the first edge, so no compare yet.
      clear_inputs();
      reset = 1'b0;
      @(posedge clk);
      @(negedge clk);
      owner = -1;
      ptr   = 0;
      #1;
      check("reset_oreq", 256'(oreq), 256'(0));
      check("reset_iresps", 256'(iresps), 256'(0));
      reset = 1'b1;

      // Vector table
      for (int r = 0; r < 13; r++) begin
         cbus_req_t e;
         for (int i = 0; i < N; i++) ireqs[i].valid = tbl[r].v[i];
         oresp.ready = tbl[r].rdy;
         oresp.last  = tbl[r].lst;
         oresp.data  = 64'hD0 + 64'(r);
         #1;
         e = '0;
         if (tbl[r].exp_owner >= 0) e = ireqs[tbl[r].exp_owner];
         check("tbl_oreq", 256'(oreq), 256'(e));
         if (tbl[r].exp_owner >= 0)
            check("tbl_iresp", 256'(iresps[tbl[r].exp_owner]), 256'(oresp));
         step();
      end

      // Single 16-beat request on port 1
      do_reset();
      ireqs[1].valid = 1'b1;
      ireqs[1].len   = MLEN16;
      oresp.ready    = 1'b1;
      #1;
      check("single_no_comb_path", 256'(oreq.valid), 256'(0));
      step();
      beats = 0;
      for (int b = 1; b <= 16; b++) begin
         oresp.last = (b == 16);
         oresp.data = 64'hBEEF_0000 + 64'(b);
         #1;
         check("single_oreq_valid", 256'(oreq.valid), 256'(1));
         check("single_loser_zero", 256'(iresps[0]), 256'(0));
         if (iresps[1].ready) beats++;
         step();
      end
      ireqs[1].valid = 1'b0;
      oresp.last     = 1'b0;
      #1;
      check("single_idle_t17", 256'(oreq), 256'(0));
      check("single_beats", 256'(beats), 256'(16));
      step();

      // Lock: port 1 arrives during beat 5 of port 0's burst
      clear_inputs();
      ireqs[0].valid = 1'b1;
      ireqs[0].len   = MLEN8;
      oresp.ready    = 1'b1;
      step();
      for (int b = 1; b <= 8; b++) begin
         if (b >= 5) ireqs[1].valid = 1'b1;
         oresp.last = (b == 8);
         #1;
         check("lock_addr", 256'(oreq.addr), 256'(64'h1000));
         check("lock_loser_zero", 256'(iresps[1]), 256'(0));
         step();
      end
      ireqs[0].valid = 1'b0;
      oresp.ready    = 1'b0;
      oresp.last     = 1'b0;
      #1;
      check("lock_bubble", 256'(oreq), 256'(0));
      step();
      oresp.ready = 1'b1;
      oresp.last  = 1'b1;
      #1;
      check("lock_next_grant", 256'(oreq), 256'(ireqs[1]));
      step();

      // Uncached write, ready delayed 3 cycles
      clear_inputs();
      ireqs[1].valid    = 1'b1;
      ireqs[1].is_write = 1'b1;
      ireqs[1].len      = MLEN1;
      ireqs[1].strobe   = 8'h0F;
      step();
      beats = 0;
      for (int c = 0; c < 4; c++) begin
         oresp.ready = (c == 3);
         oresp.last  = (c == 3);
         #1;
         check("uc_strobe", 256'(oreq.strobe), 256'(8'h0F));
         if (iresps[1].ready) beats++;
         step();
      end
      ireqs[1].valid = 1'b0;
      oresp          = '0;
      #1;
      check("uc_single_beat", 256'(beats), 256'(1));
      check("uc_idle", 256'(oreq), 256'(0));
      step();

      // Starvation: both ports hold valid, single-beat bursts
      do_reset();
      ireqs[0].valid = 1'b1;
      ireqs[1].valid = 1'b1;
      oresp.ready    = 1'b1;
      oresp.last     = 1'b1;
      grants.delete();
      for (int c = 0; c < 8; c++) begin
         #1;
         if (oreq.valid) grants.push_back(oreq.addr == 64'h2000 ? 1 : 0);
         step();
      end
      check("starve_count", 256'(grants.size()), 256'(4));
      for (int g = 0; g < 4 && g < grants.size(); g++)
         check("starve_order", 256'(grants[g]), 256'(RR ? (g % 2) : 0));
      ireqs[0].valid = 1'b0;
      first_grant    = -1;
      for (int c = 0; c < 4; c++) begin
         #1;
         if (oreq.valid && first_grant < 0) first_grant = (oreq.addr == 64'h2000) ? 1 : 0;
         step();
      end
      check("starve_port1_after_drop", 256'(first_grant), 256'(1));

      // Reset during beat 8
      clear_inputs();
      ireqs[0].valid = 1'b1;
      ireqs[0].len   = MLEN16;
      oresp.ready    = 1'b1;
      step();
      for (int b = 1; b <= 7; b++) step();
      reset = 1'b0;
      step();
      reset = 1'b1;
      #1;
      check("rst_mid_oreq", 256'(oreq), 256'(0));
      check("rst_mid_iresps", 256'(iresps), 256'(0));
      step();
      #1;
      check("rst_regrant_port0", 256'(oreq), 256'(ireqs[0]));
      oresp.last = 1'b1;
      step();

      // Randomized traffic against the model
      for (int c = 0; c < 1500; c++) begin
         reset = ($urandom_range(0, 59) != 0);
         for (int i = 0; i < N; i++) begin
            ireqs[i].valid    = ($urandom_range(0, 9) < 7);
            ireqs[i].is_write = 1'($urandom);
            ireqs[i].size     = 3'($urandom);
            ireqs[i].addr     = {$urandom, $urandom};
            ireqs[i].strobe   = 8'($urandom);
            ireqs[i].data     = {$urandom, $urandom};
            ireqs[i].len      = MLEN4;
         end
         oresp.ready = 1'($urandom);
         oresp.last  = ($urandom_range(0, 3) == 0);
         oresp.data  = {$urandom, $urandom};
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
